// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS main controller and its datapath.
// The master side is the controller; the slave side is the datapath/memory.
interface mips_multicycle_ctrl_if #(
    parameter int CNT_W = 32
) ();
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic [1:0]       pc_source;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic             instr_done;
    logic             illegal_op;
    logic             bus_error;
    logic [CNT_W-1:0] retired;
    logic [3:0]       dbg_state;

    // Memory handshake: mem_read/mem_write is a request held every cycle of the
    // access; mem_ready=1 in a cycle means the access completes in that cycle.
    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, instr_done, illegal_op, bus_error, retired, dbg_state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, instr_done, illegal_op, bus_error, retired, dbg_state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS32 core: sequences fetch/decode/execute/
// memory/writeback, times out stalled memory accesses and counts retired instructions.
module mips_multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    mips_multicycle_ctrl_if.master  bus
);
    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTIU = 6'b001011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_IMM_EX   = 4'd8,
        S_IMM_WB   = 4'd9,
        S_BEQ_EX   = 4'd10,
        S_JUMP     = 4'd11,
        S_FAULT    = 4'd12
    } state_t;

    state_t             state, state_nxt;
    logic [WAIT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic [CNT_W-1:0]   retired_q;
    logic               bus_error_q;
    logic               timeout;

    logic       c_pc_write, c_pc_write_cond, c_i_or_d, c_mem_read, c_mem_write;
    logic       c_ir_write, c_reg_dst, c_mem_to_reg, c_reg_write, c_alu_src_a;
    logic       c_instr_done, c_illegal_op;
    logic [1:0] c_pc_source, c_alu_src_b;
    logic [2:0] c_alu_op;

    assign timeout = (wait_cnt == WAIT_W'(MEM_WAIT_MAX)) && !bus.mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            wait_cnt    <= '0;
            retired_q   <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (c_instr_done) retired_q <= retired_q + 1'b1;
            if (state_nxt == S_FAULT) bus_error_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = '0;
        c_pc_write      = 1'b0;
        c_pc_write_cond = 1'b0;
        c_pc_source     = 2'b00;
        c_i_or_d        = 1'b0;
        c_mem_read      = 1'b0;
        c_mem_write     = 1'b0;
        c_ir_write      = 1'b0;
        c_reg_dst       = 1'b0;
        c_mem_to_reg    = 1'b0;
        c_reg_write     = 1'b0;
        c_alu_src_a     = 1'b0;
        c_alu_src_b     = 2'b00;
        c_alu_op        = 3'b000;
        c_instr_done    = 1'b0;
        c_illegal_op    = 1'b0;

        case (state)
            S_FETCH: begin
                c_mem_read  = 1'b1;
                c_alu_src_b = 2'b01;
                c_ir_write  = bus.mem_ready;
                c_pc_write  = bus.mem_ready;
                if (bus.mem_ready)  state_nxt = S_DECODE;
                else if (timeout)   state_nxt = S_FAULT;
                else                wait_cnt_nxt = wait_cnt + 1'b1;
            end
            S_DECODE: begin
                c_alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW:  state_nxt = S_MEMADR;
                    OP_R:          state_nxt = S_RTYPE_EX;
                    OP_BEQ:        state_nxt = S_BEQ_EX;
                    OP_J:          state_nxt = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTIU: state_nxt = S_IMM_EX;
                    default: begin
                        c_illegal_op = 1'b1;
                        state_nxt    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                c_alu_src_a = 1'b1;
                c_alu_src_b = 2'b10;
                state_nxt   = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                c_mem_read = 1'b1;
                c_i_or_d   = 1'b1;
                if (bus.mem_ready)  state_nxt = S_MEMWB;
                else if (timeout)   state_nxt = S_FAULT;
                else                wait_cnt_nxt = wait_cnt + 1'b1;
            end
            S_MEMWB: begin
                c_reg_write  = 1'b1;
                c_mem_to_reg = 1'b1;
                c_instr_done = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_MEMWR: begin
                c_mem_write  = 1'b1;
                c_i_or_d     = 1'b1;
                c_instr_done = bus.mem_ready;
                if (bus.mem_ready)  state_nxt = S_FETCH;
                else if (timeout)   state_nxt = S_FAULT;
                else                wait_cnt_nxt = wait_cnt + 1'b1;
            end
            S_RTYPE_EX: begin
                c_alu_src_a = 1'b1;
                c_alu_op    = 3'b010;
                state_nxt   = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                c_reg_write  = 1'b1;
                c_reg_dst    = 1'b1;
                c_instr_done = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_IMM_EX: begin
                c_alu_src_a = 1'b1;
                c_alu_src_b = 2'b10;
                case (bus.opcode)
                    OP_ANDI:  c_alu_op = 3'b100;
                    OP_ORI:   c_alu_op = 3'b101;
                    OP_SLTIU: c_alu_op = 3'b110;
                    default:  c_alu_op = 3'b000;
                endcase
                state_nxt = S_IMM_WB;
            end
            S_IMM_WB: begin
                c_reg_write  = 1'b1;
                c_instr_done = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_BEQ_EX: begin
                c_alu_src_a     = 1'b1;
                c_alu_op        = 3'b001;
                c_pc_write_cond = 1'b1;
                c_pc_source     = 2'b01;
                c_instr_done    = 1'b1;
                state_nxt       = S_FETCH;
            end
            S_JUMP: begin
                c_pc_write   = 1'b1;
                c_pc_source  = 2'b10;
                c_instr_done = 1'b1;
                state_nxt    = S_FETCH;
            end
            // Only a reset leaves FAULT; the datapath sees no strobes meanwhile.
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_FETCH;
        endcase
    end

    // Every output is forced low while reset is asserted.
    assign bus.pc_write      = c_pc_write      & ~rst;
    assign bus.pc_write_cond = c_pc_write_cond & ~rst;
    assign bus.pc_source     = rst ? 2'b00 : c_pc_source;
    assign bus.i_or_d        = c_i_or_d        & ~rst;
    assign bus.mem_read      = c_mem_read      & ~rst;
    assign bus.mem_write     = c_mem_write     & ~rst;
    assign bus.ir_write      = c_ir_write      & ~rst;
    assign bus.reg_dst       = c_reg_dst       & ~rst;
    assign bus.mem_to_reg    = c_mem_to_reg    & ~rst;
    assign bus.reg_write     = c_reg_write     & ~rst;
    assign bus.alu_src_a     = c_alu_src_a     & ~rst;
    assign bus.alu_src_b     = rst ? 2'b00 : c_alu_src_b;
    assign bus.alu_op        = rst ? 3'b000 : c_alu_op;
    assign bus.instr_done    = c_instr_done    & ~rst;
    assign bus.illegal_op    = c_illegal_op    & ~rst;
    assign bus.bus_error     = bus_error_q     & ~rst;
    assign bus.retired       = rst ? '0 : retired_q;
    assign bus.dbg_state     = rst ? 4'd0 : state;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: an instruction-level model expands each
// opcode into its expected per-cycle control words, compared against the DUT outputs.
module tb_mips_multicycle_ctrl;
    localparam int W = 20;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
        logic       bus_error;
    } ctrl_t;

    // A step is one phase of an instruction; memory steps repeat until mem_ready.
    typedef struct packed {
        logic  is_mem;
        ctrl_t busy;
        ctrl_t done;
    } step_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.CNT_W(32)) bus ();
    mips_multicycle_ctrl #(.MEM_WAIT_MAX(15), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ctrl_t act;
    always_comb act = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d,
                       bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
                       bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                       bus.alu_op, bus.instr_done, bus.illegal_op, bus.bus_error};

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    step_t        steps[$];
    int           exp_retired;

    // ---------------- reference model ----------------
    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
            6'b001000, 6'b001100, 6'b001101, 6'b001011: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ctrl_t fetch_word(input logic rdy);
        ctrl_t c = '0;
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.ir_write  = rdy;
        c.pc_write  = rdy;
        return c;
    endfunction

    function automatic ctrl_t fault_word();
        ctrl_t c = '0;
        c.bus_error = 1'b1;
        return c;
    endfunction

    function automatic void add_step(input logic m, input ctrl_t b, input ctrl_t d);
        step_t s;
        s.is_mem = m;
        s.busy   = b;
        s.done   = d;
        steps.push_back(s);
    endfunction

    function automatic void plan(input logic [5:0] op);
        ctrl_t a, b;
        steps.delete();
        add_step(1'b1, fetch_word(1'b0), fetch_word(1'b1));
        a = '0;
        a.alu_src_b  = 2'b11;
        a.illegal_op = !is_legal(op);
        add_step(1'b0, a, a);
        if (op == 6'b100011 || op == 6'b101011) begin
            a = '0; a.alu_src_a = 1'b1; a.alu_src_b = 2'b10;
            add_step(1'b0, a, a);
            if (op == 6'b100011) begin
                a = '0; a.mem_read = 1'b1; a.i_or_d = 1'b1;
                add_step(1'b1, a, a);
                a = '0; a.reg_write = 1'b1; a.mem_to_reg = 1'b1; a.instr_done = 1'b1;
                add_step(1'b0, a, a);
            end else begin
                a = '0; a.mem_write = 1'b1; a.i_or_d = 1'b1;
                b = a;  b.instr_done = 1'b1;
                add_step(1'b1, a, b);
            end
        end else if (op == 6'b000000) begin
            a = '0; a.alu_src_a = 1'b1; a.alu_op = 3'b010;
            add_step(1'b0, a, a);
            a = '0; a.reg_write = 1'b1; a.reg_dst = 1'b1; a.instr_done = 1'b1;
            add_step(1'b0, a, a);
        end else if (op == 6'b000100) begin
            a = '0; a.alu_src_a = 1'b1; a.alu_op = 3'b001; a.pc_write_cond = 1'b1;
            a.pc_source = 2'b01; a.instr_done = 1'b1;
            add_step(1'b0, a, a);
        end else if (op == 6'b000010) begin
            a = '0; a.pc_write = 1'b1; a.pc_source = 2'b10; a.instr_done = 1'b1;
            add_step(1'b0, a, a);
        end else if (is_legal(op)) begin
            a = '0; a.alu_src_a = 1'b1; a.alu_src_b = 2'b10;
            a.alu_op = (op == 6'b001100) ? 3'b100 : (op == 6'b001101) ? 3'b101 :
                       (op == 6'b001011) ? 3'b110 : 3'b000;
            add_step(1'b0, a, a);
            a = '0; a.reg_write = 1'b1; a.instr_done = 1'b1;
            add_step(1'b0, a, a);
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic tick(input logic rdy);
        @(negedge clk);
        bus.mem_ready = rdy;
        #2;
        got_q.push_back(act);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        repeat (n) tick(1'($urandom_range(0, 1)));
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        exp_retired = 0;
    endtask

    // fixed_wait < 0 picks random wait counts (mostly 0, sometimes up to the limit).
    task automatic exec_instr(input logic [5:0] op, input int fixed_wait);
        int waits;
        bus.opcode = op;
        plan(op);
        foreach (steps[i]) begin
            if (steps[i].is_mem) begin
                if (fixed_wait >= 0) waits = fixed_wait;
                else waits = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 0;
                for (int w = 0; w <= waits; w++) begin
                    exp_q.push_back((w == waits) ? steps[i].done : steps[i].busy);
                    tick(w == waits);
                end
            end else begin
                exp_q.push_back(steps[i].busy);
                tick(1'($urandom_range(0, 1)));
            end
        end
        if (is_legal(op)) exp_retired++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [W-1:0] g;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            g = got_q.pop_back();
            n_cmp++;
            if (g !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs cyc=%0d got=%05h exp=00000", i, g);
            end
        end
        n_cmp++;
        if (bus.retired !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_retired got=%0d exp=0", bus.retired);
        end
        rst = 1'b0;
        tick(1'b0);
        g = got_q.pop_back();
        n_cmp++;
        if (g !== fetch_word(1'b0)) begin
            n_bad++;
            $display("FAIL reset_first_fetch got=%05h exp=%05h", g, fetch_word(1'b0));
        end
        got_q.delete();
    endtask

    task automatic test_rst_mid_lw();
        logic [W-1:0] g;
        apply_reset(2);
        exec_instr(6'b000000, 0);
        exp_q.delete();
        got_q.delete();
        bus.opcode = 6'b100011;
        tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b0);
        got_q.delete();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'($urandom_range(0, 1)));
            g = got_q.pop_back();
            n_cmp++;
            if (g !== '0 || bus.retired !== 32'd0) begin
                n_bad++;
                $display("FAIL mid_lw_rst cyc=%0d got=%05h/%0d exp=00000/0", i, g, bus.retired);
            end
        end
        rst = 1'b0;
        tick(1'b1);
        g = got_q.pop_back();
        n_cmp++;
        if (g !== fetch_word(1'b1) || bus.retired !== 32'd0) begin
            n_bad++;
            $display("FAIL mid_lw_refetch got=%05h/%0d exp=%05h/0", g, bus.retired, fetch_word(1'b1));
        end
        got_q.delete();
    endtask

    task automatic test_sequence(input string name, input logic [5:0] ops[], input int fixed_wait);
        logic [W-1:0] e, g;
        int k = 0;
        apply_reset(2);
        foreach (ops[i]) exec_instr(ops[i], fixed_wait);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL %s cyc=%0d got=%05h exp=%05h", name, k, g, e);
            end
            k++;
        end
        n_cmp++;
        if (bus.retired !== 32'(exp_retired)) begin
            n_bad++;
            $display("FAIL %s_retired got=%0d exp=%0d", name, bus.retired, exp_retired);
        end
        got_q.delete();
    endtask

    task automatic test_fault();
        logic [W-1:0] g;
        apply_reset(2);
        bus.opcode = 6'($urandom_range(0, 63));
        for (int i = 0; i < 16; i++) begin
            tick(1'b0);
            g = got_q.pop_back();
            n_cmp++;
            if (g !== fetch_word(1'b0)) begin
                n_bad++;
                $display("FAIL fault_wait cyc=%0d got=%05h exp=%05h", i, g, fetch_word(1'b0));
            end
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'($urandom_range(0, 1)));
            g = got_q.pop_back();
            n_cmp++;
            if (g !== fault_word() || bus.retired !== 32'd0) begin
                n_bad++;
                $display("FAIL fault_hold cyc=%0d got=%05h/%0d exp=%05h/0", i, g, bus.retired, fault_word());
            end
        end
        apply_reset(1);
        tick(1'b1);
        g = got_q.pop_back();
        n_cmp++;
        if (g !== fetch_word(1'b1)) begin
            n_bad++;
            $display("FAIL fault_cleared got=%05h exp=%05h", g, fetch_word(1'b1));
        end
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [5:0] legal[9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                                 6'b001000, 6'b001100, 6'b001101, 6'b001011};
        logic [5:0] ops[];
        logic [5:0] op;
        ops = new[60];
        foreach (ops[i]) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom_range(0, 63)); while (is_legal(op));
            end else begin
                op = legal[$urandom_range(0, 8)];
            end
            ops[i] = op;
        end
        test_sequence("random_mix", ops, -1);
    endtask

    initial begin
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        bus.opcode = 6'b0;
        exp_retired = 0;
        test_reset();
        test_rst_mid_lw();
        test_sequence("rtype_lw", '{6'b000000, 6'b100011}, 0);
        test_sequence("ori", '{6'b001101}, 0);
        test_sequence("imm_class", '{6'b001000, 6'b001100, 6'b001011}, 0);
        test_sequence("beq_j", '{6'b000100, 6'b000010}, 0);
        test_sequence("illegal", '{6'b111111, 6'b010001, 6'b000000}, 0);
        test_sequence("wait_limit", '{6'b101011, 6'b100011}, 15);
        test_fault();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timeout");
    end
endmodule
